// File: rtl/spmv_pkg.sv
// spmv_pkg: shared state encodings, sizing helper and packing defaults for the SpMV datapath
package spmv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int DEF_DATA_LEN = 32;
   localparam int DEF_M        = 8;
   localparam int DEF_N        = 8;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/row_dot_product.sv
// row_dot_product: N registered signed multipliers feeding a combinational sum, plus row non-zero popcount
module row_dot_product
   import spmv_pkg::*;
#(
   parameter int DATA_LEN = DEF_DATA_LEN,
   parameter int N        = DEF_N,
   parameter int ACC_LEN  = 2*DATA_LEN + clog2(N),
   parameter int PW       = clog2(N+1)
)(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [DATA_LEN*N-1:0] i_row,
   input  logic [DATA_LEN*N-1:0] i_vec,
   output logic [ACC_LEN-1:0]    o_sum,
   output logic [PW-1:0]         o_pop
);

   logic signed [2*DATA_LEN-1:0] prod_q [N];

   // one full-width signed product per column, registered each cycle
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int j = 0; j < N; j++) prod_q[j] <= '0;
      end else begin
         for (int j = 0; j < N; j++)
            prod_q[j] <= $signed(i_row[DATA_LEN*j +: DATA_LEN]) * $signed(i_vec[DATA_LEN*j +: DATA_LEN]);
      end
   end

   // sign-extended product sum (wraps modulo 2^ACC_LEN) and popcount of the row being issued
   always_comb begin
      o_sum = '0;
      o_pop = '0;
      for (int j = 0; j < N; j++) begin
         o_sum = o_sum + ACC_LEN'(prod_q[j]);
         o_pop = o_pop + PW'(|i_row[DATA_LEN*j +: DATA_LEN]);
      end
   end

endmodule

// File: rtl/mat_vec_mac.sv
// mat_vec_mac: row-sequential dense matrix-vector multiply-accumulate with non-zero count
module mat_vec_mac
   import spmv_pkg::*;
#(
   parameter int DATA_LEN = DEF_DATA_LEN,
   parameter int M        = DEF_M,
   parameter int N        = DEF_N,
   parameter int ACC_LEN  = 2*DATA_LEN + clog2(N),
   parameter int NNZ_LEN  = clog2(M*N+1)
)(
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic                    i_clear,
   input  logic [DATA_LEN*M*N-1:0] i_mat,
   input  logic [DATA_LEN*N-1:0]   i_vec,
   output logic [ACC_LEN*M-1:0]    o_result,
   output logic [NNZ_LEN-1:0]      o_nnz,
   output logic                    o_release,
   output logic [1:0]              o_state,
   output logic                    o_done
);

   localparam int RW = (M > 1) ? clog2(M) : 1;
   localparam int PW = clog2(N+1);

   state_e                  state_q, state_d;
   logic [DATA_LEN*M*N-1:0] mat_q;
   logic [DATA_LEN*N-1:0]   vec_q;
   logic [RW-1:0]           row_q, idx_q;
   logic                    vld_q, rel_q;
   logic [ACC_LEN*M-1:0]    res_q;
   logic [NNZ_LEN-1:0]      nnz_q;
   logic [DATA_LEN*N-1:0]   row;
   logic [ACC_LEN-1:0]      sum;
   logic [PW-1:0]           pop;
   logic                    go, last;

   assign go   = (state_q == IDLE) && i_start;
   assign last = row_q == RW'(M-1);
   assign row  = mat_q[DATA_LEN*N*row_q +: DATA_LEN*N];

   row_dot_product #(
      .DATA_LEN(DATA_LEN),
      .N       (N),
      .ACC_LEN (ACC_LEN),
      .PW      (PW)
   ) u_dot (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_row(row),
      .i_vec(vec_q),
      .o_sum(sum),
      .o_pop(pop)
   );

   // next state: clear has priority in DONE, so start is only seen once back in IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (i_start) state_d = RUN;
         RUN:   if (last) state_d = DRAIN;
         DRAIN: state_d = DONE;
         DONE:  if (i_clear) state_d = IDLE;
      endcase
   end

   // snapshot capture, row issue, nnz accumulation and delayed result write-back
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         mat_q   <= '0;
         vec_q   <= '0;
         row_q   <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
         rel_q   <= 1'b0;
         res_q   <= '0;
         nnz_q   <= '0;
      end else begin
         state_q <= state_d;
         rel_q   <= go;
         vld_q   <= state_q == RUN;
         idx_q   <= row_q;
         if (go) begin
            mat_q <= i_mat;
            vec_q <= i_vec;
            res_q <= '0;
            nnz_q <= '0;
            row_q <= '0;
         end else begin
            if (state_q == RUN) begin
               nnz_q <= nnz_q + NNZ_LEN'(pop);
               row_q <= last ? '0 : row_q + 1'b1;
            end
            if (vld_q) res_q[ACC_LEN*idx_q +: ACC_LEN] <= sum;
         end
      end
   end

   assign o_result  = res_q;
   assign o_nnz     = nnz_q;
   assign o_release = rel_q;
   assign o_state   = state_q;
   assign o_done    = state_q == DONE;

endmodule

// File: tb/tb_mat_vec_mac.sv
// tb_mat_vec_mac: directed table-driven checks plus corner-case sequences for mat_vec_mac
module tb_mat_vec_mac;

   localparam int DL = 32, M = 8, N = 8, AL = 67, NL = 7;

   typedef logic [DL*M*N-1:0] mat_t;
   typedef logic [DL*N-1:0]   x_t;
   typedef logic [AL*M-1:0]   res_t;
   typedef struct {
      mat_t           mat;
      x_t             x;
      res_t           y;
      logic [NL-1:0]  nnz;
   } case_t;

   logic          i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0, i_clear = 1'b0;
   mat_t          i_mat = '0;
   x_t            i_vec = '0;
   res_t          o_result;
   logic [NL-1:0] o_nnz;
   logic          o_release, o_done;
   logic [1:0]    o_state;

   int    errs = 0, checks = 0;
   case_t tbl[4];

   mat_vec_mac dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_start  (i_start),
      .i_clear  (i_clear),
      .i_mat    (i_mat),
      .i_vec    (i_vec),
      .o_result (o_result),
      .o_nnz    (o_nnz),
      .o_release(o_release),
      .o_state  (o_state),
      .o_done   (o_done)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input int t, input res_t y, input logic [NL-1:0] n);
      for (int r = 0; r < M; r++)
         chk($sformatf("case%0d y[%0d]", t, r), 128'(o_result[AL*r +: AL]), 128'(y[AL*r +: AL]));
      chk($sformatf("case%0d nnz", t), 128'(o_nnz), 128'(n));
   endtask

   task automatic wait_done(input int t, input int first_rel);
      int lat, rels;
      lat  = 0;
      rels = first_rel;
      while (!o_done && lat < 50) begin
         @(posedge i_clk); #1;
         lat++;
         rels += int'(o_release);
      end
      chk($sformatf("case%0d latency", t), lat, 9);
      chk($sformatf("case%0d release_count", t), rels, 1);
   endtask

   task automatic run_op(input mat_t m, input x_t x, input int t);
      i_mat   = m;
      i_vec   = x;
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      chk($sformatf("case%0d release_after_start", t), o_release, 1);
      chk($sformatf("case%0d state_run", t), o_state, 1);
      wait_done(t, int'(o_release));
   endtask

   task automatic clear_op();
      i_clear = 1'b1;
      @(posedge i_clk); #1;
      i_clear = 1'b0;
      chk("clear_to_idle", o_state, 0);
   endtask

   initial begin
      for (int t = 0; t < 4; t++) begin
         tbl[t].mat = '0;
         tbl[t].x   = '0;
         tbl[t].y   = '0;
      end
      for (int r = 0; r < M; r++) begin
         tbl[0].mat[DL*(N*r+r) +: DL] = 32'd1;
         tbl[0].x[DL*r +: DL]         = DL'(r + 1);
         tbl[0].y[AL*r +: AL]         = AL'(r + 1);
         tbl[1].x[DL*r +: DL]         = 32'd3;
         tbl[1].y[AL*r +: AL]         = AL'(-24);
         tbl[2].x[DL*r +: DL]         = 32'h7FFF_FFFF;
         tbl[2].y[AL*r +: AL]         = 67'h1_FFFF_FFF8_0000_0008;
         tbl[3].mat[DL*(N*r) +: DL]   = DL'(r - 4);
         tbl[3].x[DL*r +: DL]         = DL'(100 * r + 5);
         tbl[3].y[AL*r +: AL]         = AL'(5 * (r - 4));
         for (int j = 0; j < N; j++) begin
            tbl[1].mat[DL*(N*r+j) +: DL] = 32'hFFFF_FFFF;
            tbl[2].mat[DL*(N*r+j) +: DL] = 32'h7FFF_FFFF;
         end
      end
      tbl[0].nnz = NL'(8);
      tbl[1].nnz = NL'(64);
      tbl[2].nnz = NL'(64);
      tbl[3].nnz = NL'(7);

      #3;
      chk("reset state", o_state, 0);
      chk("reset result", 128'(|o_result), 0);
      chk("reset nnz", o_nnz, 0);
      chk("reset release", o_release, 0);
      chk("reset done", o_done, 0);
      #9 i_rst = 1'b0;
      @(posedge i_clk); #1;

      for (int t = 0; t < 4; t++) begin
         run_op(tbl[t].mat, tbl[t].x, t);
         chk_out(t, tbl[t].y, tbl[t].nnz);
         clear_op();
      end

      i_mat   = tbl[0].mat;
      i_vec   = tbl[0].x;
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_mat = tbl[1].mat;
      i_vec = tbl[1].x;
      wait_done(10, int'(o_release));
      chk_out(10, tbl[0].y, tbl[0].nnz);
      repeat (3) @(posedge i_clk);
      #1;
      chk("done holds with start high", o_state, 3);
      i_start = 1'b0;
      clear_op();

      run_op(tbl[3].mat, tbl[3].x, 11);
      i_mat   = tbl[0].mat;
      i_vec   = tbl[0].x;
      i_clear = 1'b1;
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_clear = 1'b0;
      chk("clear wins state", o_state, 0);
      chk("clear wins done", o_done, 0);
      chk("clear wins no release", o_release, 0);
      @(posedge i_clk); #1;
      i_start = 1'b0;
      chk("restart state", o_state, 1);
      chk("restart result zeroed", 128'(|o_result), 0);
      chk("restart nnz zeroed", o_nnz, 0);
      wait_done(12, int'(o_release));
      chk_out(12, tbl[0].y, tbl[0].nnz);
      clear_op();

      i_mat   = tbl[1].mat;
      i_vec   = tbl[1].x;
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      chk("pre-reset nnz", o_nnz, 24);
      #1 i_rst = 1'b1;
      #1;
      chk("async reset state", o_state, 0);
      chk("async reset result", 128'(|o_result), 0);
      chk("async reset nnz", o_nnz, 0);
      chk("async reset release", o_release, 0);
      chk("async reset done", o_done, 0);
      @(posedge i_clk); #2;
      i_rst = 1'b0;
      @(posedge i_clk); #1;
      chk("post-reset idle", o_state, 0);
      run_op(tbl[2].mat, tbl[2].x, 13);
      chk_out(13, tbl[2].y, tbl[2].nnz);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/mat_vec_mac.md
# mat_vec_mac

Row-sequential dense matrix-vector multiply-accumulate stage of the SpMV datapath. Consumes the flattened M×N matrix produced by the M10K read buffer and an N-element operand vector. On start it snapshots both inputs, then streams one matrix row per cycle through an N-wide multiply / adder-tree pipeline. It presents the M-element result vector and a count of non-zero matrix elements, and holds both until cleared.

## Interface
- DATA_LEN, 32, signed element width (matrix and vector)
- M, 8, matrix rows / result elements
- N, 8, matrix columns / vector elements
- ACC_LEN, 67, result element width (2*DATA_LEN + clog2(N) gives no overflow)
- NNZ_LEN, 7, non-zero counter width (clog2(M*N+1))
- One clock; reset is asynchronous and active-high.
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  asynchronous active-high reset
- i_start  in  1  level; accepted only in IDLE
- i_clear  in  1  level; accepted only in DONE, returns to IDLE
- i_mat  in  DATA_LEN*M*N  row r at [DATA_LEN*N*r +: DATA_LEN*N], element j of a row at [DATA_LEN*j +: DATA_LEN]
- i_vec  in  DATA_LEN*N  element j at [DATA_LEN*j +: DATA_LEN]
- o_result  out  ACC_LEN*M  y[r] at [ACC_LEN*r +: ACC_LEN]
- o_nnz  out  NNZ_LEN  count of non-zero elements in the snapshot matrix
- o_release  out  1  one-cycle pulse: snapshot taken, upstream may reset (drives read buffer's read-reset)
- o_state  out  2  IDLE=0, RUN=1, DRAIN=2, DONE=3
- o_done  out  1  state == DONE

## Operation
- IDLE: i_start=1 → RUN. On the same edge, capture i_mat and i_vec into snapshot registers, zero o_result and o_nnz, and set row counter to 0.
- RUN: each cycle issue snapshot row[row_cnt] to the dot-product unit, add that row's non-zero popcount to o_nnz, and increment row_cnt. After row M-1 is issued → DRAIN.
- DRAIN: one cycle. The last row's sum is written. → DONE.
- DONE: o_result and o_nnz hold. i_clear=1 → IDLE. Otherwise stay.
- Arithmetic: products are signed DATA_LEN×DATA_LEN → 2*DATA_LEN. Sum is sign-extended to ACC_LEN. If ACC_LEN is set below the no-overflow width, the result wraps modulo 2^ACC_LEN; there is no saturation.
- i_start outside IDLE is ignored. i_clear outside DONE is ignored.
- i_start and i_clear both high in DONE: clear wins → IDLE. Start is not accepted that cycle; it is accepted on the next cycle if still high.
- i_mat/i_vec changes after the capture edge have no effect on the current operation.
- i_rst asserted at any time, including mid-RUN: state=IDLE, snapshots, o_result, o_nnz, row_cnt and pipeline registers all 0, o_release=0. Takes effect immediately, without waiting for a clock edge.
- M=1 is legal: a single RUN cycle.

## Timing
- Edge 0: start accepted. o_release=1 during the following cycle only.
- Edge e (1..M): products of row e-1 are registered.
- Edge e+1: result[e-1] is written.
- Last result at edge M+1. o_done=1 from edge M+1 onward. Latency is M+1 cycles from start acceptance; 9 for M=8.
- o_nnz is final after edge M.
- Back-to-back operation is possible: clear, then start, gives minimum 2 cycles of DONE→IDLE→RUN turnaround.
- Reset values: o_result=0, o_nnz=0, o_release=0, o_state=0, o_done=0.

## Structure
- Shared package spmv_pkg holds:
  - state encodings IDLE/RUN/DRAIN/DONE
  - clog2 function
  - DATA_LEN/M/N defaults, so the read buffer and this block agree on packing.
- Sub-module row_dot_product:
  - N registered signed multipliers plus a combinational adder tree, one sum per cycle.
  - Also emits the row's non-zero popcount.
- Top level holds the FSM, snapshots, row counter, result register file and nnz accumulator.

## Test plan
- Identity matrix, x=[1..8]: start → y=[1,2,3,4,5,6,7,8], o_nnz=8, o_done rises exactly 9 cycles after the start edge, o_release is a single pulse one cycle after the start edge.
- All elements -1, x all 3: → every y=-24 (sign-extended, ACC_LEN bits), o_nnz=64.
- All elements 32'h7FFFFFFF, x same: → every y=8*(2^31-1)^2 exact, no wrap.
- i_mat changed and i_start held high during RUN: results match the pre-change snapshot, and no restart occurs.
- In DONE, i_clear=1 together with i_start=1 for one cycle: → IDLE, start not accepted. With i_start then held: → RUN on the following edge, o_result zeroed.
- i_rst asserted at the 4th RUN cycle: all outputs 0 and state IDLE immediately. After release, a fresh start yields a correct full result.
